// File: rtl/lcd_frame_sched.sv
// Frame-buffer scheduler: hands the SDRAM frame writer a free buffer and swaps the
// LCD display buffer only at frame sync so the panel never shows a torn frame.
//
// state    | meaning
// W_IDLE   | no frame in progress, waiting for wr_frame_start
// W_ALLOC  | choosing a buffer for the writer (one cycle)
// W_ACTIVE | writer owns a buffer, waiting for wr_frame_done
module lcd_frame_sched #(
    parameter int                NBUF       = 3,
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'h000000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE = 24'h020000
) (
    input  logic              clk_lcd,
    input  logic              lcd_rst,
    input  logic              wr_frame_start,
    input  logic              wr_frame_done,
    output logic              wr_grant,
    output logic [ADDR_W-1:0] wr_base,
    output logic              wr_busy,
    input  logic              lcd_framesync,
    input  logic              sdr_addr_set,
    input  logic              key1,
    output logic [ADDR_W-1:0] rd_base,
    output logic              rd_addr_load,
    output logic              disp_valid,
    output logic [7:0]        drop_cnt
);

    localparam int IDX_W = 2;

    typedef enum logic [1:0] {W_IDLE, W_ALLOC, W_ACTIVE} w_state_t;
    typedef enum logic [1:0] {B_FREE, B_WRITING, B_READY, B_DISPLAY} buf_state_t;

    w_state_t          w_state, w_state_n;
    buf_state_t        buf_st   [NBUF];
    buf_state_t        buf_st_n [NBUF];
    logic [ADDR_W-1:0] rd_base_n, wr_base_n;
    logic              grant_n, drop_inc, swap;
    logic              ready_found, pick_found;
    logic [IDX_W-1:0]  ready_idx, pick_idx;

    function automatic logic [ADDR_W-1:0] buf_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + ADDR_W'(idx) * BUF_STRIDE;
    endfunction

    always_comb begin
        buf_st_n    = buf_st;
        w_state_n   = w_state;
        rd_base_n   = rd_base;
        wr_base_n   = wr_base;
        grant_n     = 1'b0;
        drop_inc    = 1'b0;
        swap        = 1'b0;
        ready_found = 1'b0;
        ready_idx   = '0;
        pick_found  = 1'b0;
        pick_idx    = '0;

        // A finished frame retires first so a same-cycle framesync can display it.
        if (w_state == W_ACTIVE && wr_frame_done) begin
            for (int i = 0; i < NBUF; i++) begin
                if (buf_st_n[i] == B_READY) begin
                    buf_st_n[i] = B_FREE;
                    drop_inc    = 1'b1;
                end else if (buf_st_n[i] == B_WRITING) begin
                    buf_st_n[i] = B_READY;
                end
            end
            w_state_n = W_IDLE;
        end

        for (int i = 0; i < NBUF; i++) begin
            if (buf_st_n[i] == B_READY) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end

        if (lcd_framesync && !key1 && ready_found) begin
            swap      = 1'b1;
            rd_base_n = buf_addr(ready_idx);
            for (int i = 0; i < NBUF; i++) begin
                if (IDX_W'(i) == ready_idx) begin
                    buf_st_n[i] = B_DISPLAY;
                end else if (buf_st_n[i] == B_DISPLAY) begin
                    buf_st_n[i] = B_FREE;
                end
            end
        end

        case (w_state)
            W_IDLE: begin
                if (wr_frame_start) begin
                    w_state_n = W_ALLOC;
                end
            end
            W_ALLOC: begin
                for (int i = NBUF - 1; i >= 0; i--) begin
                    if (buf_st_n[i] == B_FREE) begin
                        pick_found = 1'b1;
                        pick_idx   = IDX_W'(i);
                    end
                end
                // With only two buffers nothing may be FREE; reuse the undisplayed frame.
                if (!pick_found) begin
                    for (int i = 0; i < NBUF; i++) begin
                        if (buf_st_n[i] == B_READY) begin
                            pick_found = 1'b1;
                            pick_idx   = IDX_W'(i);
                            drop_inc   = 1'b1;
                        end
                    end
                end
                for (int i = 0; i < NBUF; i++) begin
                    if (pick_found && IDX_W'(i) == pick_idx) begin
                        buf_st_n[i] = B_WRITING;
                    end
                end
                wr_base_n = buf_addr(pick_idx);
                grant_n   = 1'b1;
                w_state_n = W_ACTIVE;
            end
            W_ACTIVE: begin
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_lcd or negedge lcd_rst) begin
        if (!lcd_rst) begin
            w_state <= W_IDLE;
            for (int i = 0; i < NBUF; i++) begin
                buf_st[i] <= (i == 0) ? B_DISPLAY : B_FREE;
            end
            rd_base      <= BASE_ADDR;
            wr_base      <= BASE_ADDR;
            wr_grant     <= 1'b0;
            rd_addr_load <= 1'b0;
            disp_valid   <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            w_state      <= w_state_n;
            buf_st       <= buf_st_n;
            rd_base      <= rd_base_n;
            wr_base      <= wr_base_n;
            wr_grant     <= grant_n;
            rd_addr_load <= swap | sdr_addr_set;
            if (swap) begin
                disp_valid <= 1'b1;
            end
            if (drop_inc && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign wr_busy = (w_state == W_ACTIVE);

endmodule
